// File: rtl/tenyr_run_ctl.sv
//------------------------------------------------------------------------------
// tenyr_run_ctl
//   Power-up sequencer, halt-bus merge and debugger stop/single-step control
//   for the Tenyr core, with a count of cycles in which the core ran.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef HALTBUSWIDTH
`define HALTBUSWIDTH 2
`endif

module tenyr_run_ctl #(
    parameter int RESET_CYCLES = 40,
    parameter int PRIME_CYCLES = 10,
    parameter int NSRC         = `HALTBUSWIDTH
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NSRC-1:0] halt_in,
    input  logic            dbg_halt,
    input  logic            step_req,
    output logic            step_ack,
    output logic            cpu_reset_n,
    output logic            halt,
    output logic [2:0]      state,
    output logic [31:0]     run_count
);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_PRIME   = 3'd1,
        S_RUN     = 3'd2,
        S_STOPPED = 3'd3,
        S_STEP    = 3'd4
    } state_t;

    localparam logic [15:0] c_reset_load = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] c_prime_load = 16'(PRIME_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_step_q;
    logic        r_ack;
    logic        r_cpu_rst_n;
    logic        r_halt;
    logic [31:0] r_run_count;

    logic w_any;
    logic w_step_edge;

    assign w_any       = |halt_in;
    assign w_step_edge = step_req & ~r_step_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_RESET;
            r_cnt       <= c_reset_load;
            r_step_q    <= 1'b0;
            r_ack       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_halt      <= 1'b1;
            r_run_count <= 32'd0;
        end else begin
            r_step_q <= step_req;
            r_ack    <= 1'b0;
            if (!r_halt && r_cpu_rst_n) begin
                r_run_count <= r_run_count + 32'd1;
            end

            case (r_state)
                S_PRIME: begin
                    r_cpu_rst_n <= 1'b1;
                    r_halt      <= 1'b1;
                    if (r_cnt == 16'd0) begin
                        if (dbg_halt) begin
                            r_state <= S_STOPPED;
                        end else begin
                            r_state <= S_RUN;
                            r_halt  <= w_any;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end

                S_RUN: begin
                    if (dbg_halt) begin
                        r_state <= S_STOPPED;
                        r_halt  <= 1'b1;
                    end else begin
                        r_halt <= w_any;
                    end
                end

                // Releasing the debugger wins over a coincident step edge.
                S_STOPPED: begin
                    r_halt <= 1'b1;
                    if (!dbg_halt) begin
                        r_state <= S_RUN;
                        r_halt  <= w_any;
                    end else if (w_step_edge) begin
                        r_state <= S_STEP;
                    end
                end

                // halt low here means the single run cycle just happened.
                S_STEP: begin
                    if (!r_halt) begin
                        r_halt  <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= S_STOPPED;
                    end else if (!w_any) begin
                        r_halt <= 1'b0;
                    end
                end

                default: begin
                    r_cpu_rst_n <= 1'b0;
                    r_halt      <= 1'b1;
                    if (r_cnt == 16'd0) begin
                        r_state     <= S_PRIME;
                        r_cnt       <= c_prime_load;
                        r_cpu_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    assign step_ack    = r_ack;
    assign cpu_reset_n = r_cpu_rst_n;
    assign halt        = r_halt;
    assign state       = r_state;
    assign run_count   = r_run_count;

endmodule

`default_nettype wire

// File: tb/tb_tenyr_run_ctl.sv
//------------------------------------------------------------------------------
// tb_tenyr_run_ctl
//   Directed scenarios plus randomized traffic against a behavioural model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tenyr_run_ctl;

    localparam int R    = 40;
    localparam int P    = 10;
    localparam int NSRC = 3;

    logic            clk;
    logic            reset_n;
    logic [NSRC-1:0] halt_in;
    logic            dbg_halt;
    logic            step_req;
    logic            step_ack;
    logic            cpu_reset_n;
    logic            halt;
    logic [2:0]      state;
    logic [31:0]     run_count;

    int n_checks = 0;
    int n_fail   = 0;

    tenyr_run_ctl #(
        .RESET_CYCLES (R),
        .PRIME_CYCLES (P),
        .NSRC         (NSRC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .halt_in     (halt_in),
        .dbg_halt    (dbg_halt),
        .step_req    (step_req),
        .step_ack    (step_ack),
        .cpu_reset_n (cpu_reset_n),
        .halt        (halt),
        .state       (state),
        .run_count   (run_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: power-up phases come from the number of edges since
    // reset release; a step is a pending request that opens one run window.
    int          m_since;
    int          m_mode;
    logic        m_halt;
    logic        m_cpu;
    logic        m_ack;
    logic [31:0] m_count;
    logic        m_prev;
    logic        m_any;
    logic        m_edge;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_since = 0; m_mode = 0; m_halt = 1'b1; m_cpu = 1'b0;
            m_ack = 1'b0; m_count = 32'd0; m_prev = 1'b0;
        end else begin
            m_any  = |halt_in;
            m_edge = step_req && !m_prev;
            m_prev = step_req;
            if (!m_halt && m_cpu) m_count = m_count + 32'd1;
            m_ack   = 1'b0;
            m_since = m_since + 1;
            case (m_mode)
                0: if (m_since == R) begin m_mode = 1; m_cpu = 1'b1; end
                1: if (m_since == R + P) begin
                       if (dbg_halt) m_mode = 3;
                       else begin m_mode = 2; m_halt = m_any; end
                   end
                2: if (dbg_halt) begin m_mode = 3; m_halt = 1'b1; end
                   else m_halt = m_any;
                3: if (!dbg_halt) begin m_mode = 2; m_halt = m_any; end
                   else if (m_edge) m_mode = 4;
                default: if (!m_halt) begin m_ack = 1'b1; m_mode = 3; m_halt = 1'b1; end
                         else if (!m_any) m_halt = 1'b0;
            endcase
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; halt_in = '0; dbg_halt = 1'b0; step_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== 3'd0 || halt !== 1'b1 || cpu_reset_n !== 1'b0 ||
            step_ack !== 1'b0 || run_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: state=%0d halt=%b cpu_reset_n=%b ack=%b count=%0d, required 0 1 0 0 0",
                     state, halt, cpu_reset_n, step_ack, run_count);
        end
        reset_n = 1'b1;
    endtask

    // Entered at the negedge right after reset release with all inputs 0.
    task automatic test_powerup();
        for (int k = 1; k <= R + P + 5; k++) begin
            logic        e_cpu, e_halt;
            logic [2:0]  e_st;
            logic [31:0] e_cnt;
            @(negedge clk);
            e_cpu  = (k >= R);
            e_halt = (k < R + P);
            e_st   = (k < R) ? 3'd0 : (k < R + P) ? 3'd1 : 3'd2;
            e_cnt  = (k >= R + P) ? 32'(k - R - P) : 32'd0;
            n_checks++;
            if (cpu_reset_n !== e_cpu || halt !== e_halt || state !== e_st ||
                run_count !== e_cnt || step_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL powerup edge %0d: cpu=%b halt=%b st=%0d cnt=%0d ack=%b, required %b %b %0d %0d 0",
                         k, cpu_reset_n, halt, state, run_count, step_ack, e_cpu, e_halt, e_st, e_cnt);
            end
        end
    endtask

    task automatic test_halt_in();
        logic [31:0] b;
        b = m_count;
        halt_in = 3'b001;
        for (int i = 1; i <= 5; i++) begin
            logic e_h;
            @(negedge clk);
            if (i == 3) halt_in = '0;
            e_h = (i <= 3);
            n_checks++;
            if (halt !== e_h || run_count !== ((i == 5) ? b + 32'd2 : b + 32'd1)) begin
                n_fail++;
                $display("FAIL halt_in cycle %0d: halt=%b cnt=%0d, required %b %0d",
                         i, halt, run_count, e_h, (i == 5) ? b + 32'd2 : b + 32'd1);
            end
        end
    endtask

    task automatic test_steps();
        int          lows, acks;
        logic [31:0] b;
        dbg_halt = 1'b1;
        @(negedge clk);
        n_checks++;
        if (state !== 3'd3 || halt !== 1'b1) begin
            n_fail++;
            $display("FAIL stop: state=%0d halt=%b, required 3 1", state, halt);
        end
        b = m_count;
        lows = 0; acks = 0;
        for (int p = 0; p < 4; p++) begin
            step_req = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                step_req = 1'b0;
                if (halt === 1'b0) lows++;
                if (step_ack === 1'b1) acks++;
            end
        end
        n_checks++;
        if (lows != 4 || acks != 4 || run_count !== b + 32'd4 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL steps: lows=%0d acks=%0d cnt=%0d st=%0d, required 4 4 %0d 3",
                     lows, acks, run_count, state, b + 32'd4);
        end
    endtask

    task automatic test_step_wait();
        step_req = 1'b1;
        halt_in  = 3'b010;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            step_req = 1'b0;
            if (j == 5) halt_in = '0;
            n_checks++;
            if (halt !== 1'b1 || step_ack !== 1'b0 || state !== 3'd4) begin
                n_fail++;
                $display("FAIL step_wait hold %0d: halt=%b ack=%b st=%0d, required 1 0 4",
                         j, halt, step_ack, state);
            end
        end
        @(negedge clk);
        n_checks++;
        if (halt !== 1'b0 || step_ack !== 1'b0 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL step_wait window: halt=%b ack=%b st=%0d, required 0 0 4", halt, step_ack, state);
        end
        @(negedge clk);
        n_checks++;
        if (halt !== 1'b1 || step_ack !== 1'b1 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL step_wait ack: halt=%b ack=%b st=%0d, required 1 1 3", halt, step_ack, state);
        end
        @(negedge clk);
        n_checks++;
        if (step_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL step_wait ack pulse width: ack=%b, required 0", step_ack);
        end
    endtask

    task automatic test_release_vs_step();
        int acks;
        dbg_halt = 1'b0;
        step_req = 1'b1;
        acks = 0;
        @(negedge clk);
        step_req = 1'b0;
        n_checks++;
        if (state !== 3'd2 || halt !== 1'b0) begin
            n_fail++;
            $display("FAIL release: state=%0d halt=%b, required 2 0", state, halt);
        end
        repeat (4) begin
            @(negedge clk);
            if (step_ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks != 0 || state !== 3'd2) begin
            n_fail++;
            $display("FAIL release ack: acks=%0d st=%0d, required 0 2", acks, state);
        end
        dbg_halt = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_step();
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (halt !== 1'b0 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL mid_step window: halt=%b st=%0d, required 0 4", halt, state);
        end
        reset_n  = 1'b0;
        dbg_halt = 1'b0;
        #1;
        n_checks++;
        if (halt !== 1'b1 || cpu_reset_n !== 1'b0 || run_count !== 32'd0 ||
            state !== 3'd0 || step_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_step reset: halt=%b cpu=%b cnt=%0d st=%0d ack=%b, required 1 0 0 0 0",
                     halt, cpu_reset_n, run_count, state, step_ack);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        test_powerup();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_checks++;
            if (state !== 3'(m_mode) || halt !== m_halt || cpu_reset_n !== m_cpu ||
                step_ack !== m_ack || run_count !== m_count) begin
                n_fail++;
                $display("FAIL random cycle %0d: st=%0d halt=%b cpu=%b ack=%b cnt=%0d, required %0d %b %b %b %0d",
                         c, state, halt, cpu_reset_n, step_ack, run_count,
                         m_mode, m_halt, m_cpu, m_ack, m_count);
            end
            reset_n = !(c >= 300 && c < 302);
            for (int b = 0; b < NSRC; b++) halt_in[b] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 11) == 0) dbg_halt = ~dbg_halt;
            step_req = ($urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_halt_in();
        test_steps();
        test_step_wait();
        test_release_vs_step();
        test_reset_mid_step();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tenyr_run_ctl.md
# tenyr_run_ctl

Run controller sitting between the board/sim top and the Tenyr core. It sequences power-up (core reset, then a halted priming window, then run), merges the per-source halt requests of the halt bus into the single core halt, and adds a debugger stop/single-step mechanism with a request/acknowledge handshake. It also counts cycles in which the core actually ran.

## Interface
Parameters:
- RESET_CYCLES, 40, cycles `cpu_reset_n` is held low after `reset_n` release; legal range 1..65535
- PRIME_CYCLES, 10, cycles the core is out of reset but still halted; legal range 1..65535
- NSRC, `HALTBUSWIDTH`, number of halt request sources

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- halt_in  in  NSRC  level halt requests, one per source (the `HALT_SIM` bit included)
- dbg_halt  in  1  debugger stop request, level
- step_req  in  1  debugger single-step request; acted on at its rising edge
- step_ack  out  1  one-cycle pulse: requested step completed
- cpu_reset_n  out  1  active-low reset to the core
- halt  out  1  halt to the core
- state  out  3  current state encoding (debug visibility)
- run_count  out  32  number of cycles with `halt`=0 and `cpu_reset_n`=1

## Operation
- All outputs registered. Async reset values: state=RESET(0), `cpu_reset_n`=0, `halt`=1, `step_ack`=0, `run_count`=0, internal 16-bit down-counter=RESET_CYCLES-1, step edge-detect register=0.
- States: RESET=0, PRIME=1, RUN=2, STOPPED=3, STEP=4; other encodings unreachable, decoded as RESET.
- RESET: `cpu_reset_n`=0, `halt`=1. Counter decrements each cycle; on a cycle with counter==0 go to PRIME, load counter with PRIME_CYCLES-1.
- PRIME: `cpu_reset_n`=1, `halt`=1. On counter==0: go to STOPPED if `dbg_halt`=1, else RUN.
- RUN: `halt` <= OR of `halt_in`. If `dbg_halt`=1, go to STOPPED (`halt`=1 from the next cycle regardless of `halt_in`).
- STOPPED: `halt`=1. If `dbg_halt`=0, go to RUN. Else if a `step_req` rising edge is detected, go to STEP. `dbg_halt` release has priority over a same-cycle step edge; that step edge is discarded.
- STEP: the first cycle in which OR(`halt_in`)=0 drives `halt`=0 for exactly one cycle. The step is then complete: `step_ack` pulses for one cycle and the state returns to STOPPED. While any `halt_in` bit is high, the FSM waits in STEP with `halt`=1. `dbg_halt` changes are ignored until the return to STOPPED.
- `step_req` edges outside STOPPED are discarded. The edge detector updates every cycle.
- `run_count` increments in every cycle where the registered `halt`=0 and `cpu_reset_n`=1. It wraps from 0xFFFFFFFF to 0.
- `reset_n` assertion in any state, including mid-STEP, forces all outputs to their reset values immediately (asynchronously). No pending step or ack survives.

## Timing
- Cycle 1 is the first rising edge with `reset_n` high.
- `cpu_reset_n` rises after edge RESET_CYCLES.
- With all inputs 0, `halt` falls after edge RESET_CYCLES+PRIME_CYCLES.
- `halt_in` to `halt`, and `dbg_halt` to `halt`: 1 cycle latency in RUN.
- `step_req` edge to the `halt`=0 cycle is 2 cycles, plus any `halt_in` wait. `step_ack` is asserted in the cycle after the `halt`=0 cycle, coincident with the return to STOPPED.
- Minimum step spacing is 3 cycles. Edges arriving while in STEP are lost.

## Test plan
- Defaults, all inputs 0: `cpu_reset_n` rises after edge 40, `halt` falls after edge 50, `state`=2, `run_count`=5 five cycles later.
- In RUN, `halt_in[0]` pulses high for 3 cycles: `halt` is high for exactly those 3 cycles, delayed by 1. `run_count` stops for 3 cycles and then resumes.
- `dbg_halt`=1 in RUN, then 4 `step_req` pulses spaced 5 cycles apart: exactly 4 single-cycle `halt`=0 windows, 4 `step_ack` pulses, and `run_count` increases by 4.
- Step with `halt_in[1]`=1 for 6 cycles after the step edge: `halt` stays 1 during those cycles, then one `halt`=0 cycle, then `step_ack`.
- `dbg_halt` falls in the same cycle as a `step_req` edge in STOPPED: goes to RUN, no `step_ack`.
- `reset_n` asserted during the `halt`=0 cycle of a STEP: `halt`=1, `cpu_reset_n`=0, `run_count`=0 immediately. No `step_ack`, and the full 40/10 sequence replays.
